// File: rtl/arduino_pixel_writer.sv
// Host-write front end for the 64x48 framebuffer: decodes strobed command bytes from the Arduino,
// queues pixel writes and performs fills, writing the framebuffer only during blanking.
module arduino_pixel_writer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned NUM_PIXELS = 3072
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  bus_data,
  input  logic        bus_strobe,
  input  logic        active,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [5:0]  wr_data,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [11:0] LastAddr = 12'(NUM_PIXELS - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StFillWait,
    StFill
  } state_e;

  typedef enum logic [1:0] {
    OpAddrHi = 2'b00,
    OpAddrLo = 2'b01,
    OpPixel  = 2'b10,
    OpFill   = 2'b11
  } op_e;

  state_e state_q, state_d;

  // Strobe synchronizer and rising-edge detect
  logic strb_s1_q, strb_s2_q, strb_s3_q;
  logic pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_s1_q <= 1'b0;
      strb_s2_q <= 1'b0;
      strb_s3_q <= 1'b0;
    end else begin
      strb_s1_q <= bus_strobe;
      strb_s2_q <= strb_s1_q;
      strb_s3_q <= strb_s2_q;
    end
  end

  assign pulse = strb_s2_q & ~strb_s3_q;

  // Command decode
  op_e        op;
  logic [5:0] payload;
  logic [11:0] addr_q, addr_d;
  logic [5:0]  fill_color_q, fill_color_d;
  logic [11:0] fill_cnt_q, fill_cnt_d;
  logic        overflow_q;
  logic        push, drop, fill_cmd, fill_last, addr_valid;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [17:0]     mem_q [FIFO_DEPTH];
  logic [17:0]     head;
  logic            fifo_empty, fifo_full, fifo_pop;

  assign op         = op_e'(bus_data[7:6]);
  assign payload    = bus_data[5:0];
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == FullCnt);
  assign addr_valid = (32'(addr_q) < NUM_PIXELS);
  assign head       = mem_q[rptr_q];

  always_comb begin
    push         = 1'b0;
    drop         = 1'b0;
    fill_cmd     = 1'b0;
    addr_d       = addr_q;
    fill_color_d = fill_color_q;
    if (pulse) begin
      if (state_q != StIdle) begin
        drop = 1'b1;
      end else begin
        unique case (op)
          OpAddrHi: addr_d[11:6] = payload;
          OpAddrLo: addr_d[5:0]  = payload;
          OpPixel: begin
            // Out-of-range address silently restarts at 0 without queuing
            if (!addr_valid) begin
              addr_d = '0;
            end else if (fifo_full) begin
              drop = 1'b1;
            end else begin
              push   = 1'b1;
              addr_d = (addr_q == LastAddr) ? '0 : addr_q + 12'd1;
            end
          end
          OpFill: begin
            fill_cmd     = 1'b1;
            fill_color_d = payload;
          end
        endcase
      end
    end
    if (fill_last) begin
      addr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      fill_color_q <= '0;
      fill_cnt_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      fill_color_q <= fill_color_d;
      fill_cnt_q   <= fill_cnt_d;
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Pixel FIFO; fullness uses the pre-pop count
  always_comb begin
    case ({push, fifo_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (fifo_pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {addr_q, payload};
    end
  end

  // Fill counter
  assign fill_last = (state_q == StFill) && !active && (fill_cnt_q == LastAddr);

  always_comb begin
    fill_cnt_d = fill_cnt_q;
    if (fill_last) begin
      fill_cnt_d = '0;
    end else if ((state_q == StFill) && !active) begin
      fill_cnt_d = fill_cnt_q + 12'd1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (fill_cmd) begin
          state_d = StFillWait;
        end
      end
      StFillWait: begin
        if (fifo_empty) begin
          state_d = StFill;
        end
      end
      StFill: begin
        if (fill_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs; address and data are forced to 0 when not writing
  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    fifo_pop = 1'b0;
    case (state_q)
      StIdle, StFillWait: begin
        if (!fifo_empty && !active) begin
          wr_en    = 1'b1;
          wr_addr  = head[17:6];
          wr_data  = head[5:0];
          fifo_pop = 1'b1;
        end
      end
      StFill: begin
        if (!active) begin
          wr_en   = 1'b1;
          wr_addr = fill_cnt_q;
          wr_data = fill_color_q;
        end
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != StIdle);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_arduino_pixel_writer.sv
// Self-checking bench for arduino_pixel_writer: an expected-write queue built from the command
// semantics is checked against every framebuffer write, plus hand-computed timing and value checks.
module tb_arduino_pixel_writer;

  localparam int Depth = 4;
  localparam int NPix  = 3072;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  bus_data = 8'h00;
  logic        bus_strobe = 1'b0;
  logic        active = 1'b0;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [5:0]  wr_data;
  logic        busy;
  logic        overflow;

  arduino_pixel_writer #(
    .FIFO_DEPTH(Depth),
    .NUM_PIXELS(NPix)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_data  (bus_data),
    .bus_strobe(bus_strobe),
    .active    (active),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    bit fill;
  } exp_t;

  exp_t exp_q[$];
  int   seen_q[$];
  int   m_addr;
  int   m_cnt;
  int   m_fill_left;
  int   fill_done;
  bit   m_ovf;
  int   n_tests;
  int   n_fail;
  int   act_mode;
  int   tog_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Expected effect of one command byte on the write stream
  function automatic void model_byte(input logic [7:0] b);
    logic [5:0] p;
    exp_t e;
    p = b[5:0];
    if (m_fill_left > 0) begin
      m_ovf = 1'b1;
    end else begin
      case (b[7:6])
        2'b00: m_addr = (m_addr % 64) + int'(p) * 64;
        2'b01: m_addr = (m_addr / 64) * 64 + int'(p);
        2'b10: begin
          if (m_addr >= NPix) begin
            m_addr = 0;
          end else if (m_cnt == Depth) begin
            m_ovf = 1'b1;
          end else begin
            e.addr = m_addr;
            e.data = int'(p);
            e.fill = 1'b0;
            exp_q.push_back(e);
            m_cnt++;
            m_addr = (m_addr + 1) % NPix;
          end
        end
        default: begin
          for (int i = 0; i < NPix; i++) begin
            e.addr = i;
            e.data = int'(p);
            e.fill = 1'b1;
            exp_q.push_back(e);
          end
          m_fill_left = NPix;
          m_addr = 0;
        end
      endcase
    end
  endfunction

  // Active-video generator: 0 low, 1 high, 2 periodic blanking
  always begin
    @(posedge clk);
    #1;
    case (act_mode)
      0: active = 1'b0;
      1: active = 1'b1;
      default: begin
        tog_cnt++;
        active = (tog_cnt % 240) >= 200;
      end
    endcase
  end

  // Compare process: every framebuffer write must be the next expected one
  always @(negedge clk) begin
    if (rst_n) begin
      check("wr_en_during_active", {31'd0, wr_en & active}, 32'd0);
      if (wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", {20'd0, wr_addr}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("write_addr", {20'd0, wr_addr}, e.addr);
          check("write_data", {26'd0, wr_data}, e.data);
          seen_q.push_back(int'(wr_addr));
          if (e.fill) begin
            m_fill_left--;
            fill_done++;
          end else begin
            m_cnt--;
          end
        end
      end else begin
        check("idle_wr_en", {31'd0, wr_en}, 32'd0);
        check("idle_wr_addr", {20'd0, wr_addr}, 32'd0);
        check("idle_wr_data", {26'd0, wr_data}, 32'd0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    @(posedge clk);
    #1;
    bus_data   = b;
    bus_strobe = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    bus_strobe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("overflow_after_byte", {31'd0, overflow}, {31'd0, m_ovf});
  endtask

  task automatic wait_drain(input int bound);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < bound) begin
      @(posedge clk);
      cyc++;
    end
    check("drain_within_bound", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n      = 1'b0;
    bus_strobe = 1'b0;
    exp_q.delete();
    m_addr      = 0;
    m_cnt       = 0;
    m_fill_left = 0;
    m_ovf       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int cyc;
    n_tests = 0;
    n_fail = 0;
    act_mode = 0;
    tog_cnt = 0;
    fill_done = 0;
    m_addr = 0;
    m_cnt = 0;
    m_fill_left = 0;
    m_ovf = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("reset_wr_en", {31'd0, wr_en}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_overflow", {31'd0, overflow}, 32'd0);
    check("reset_wr_addr", {20'd0, wr_addr}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single pixel: row 5, col 10 -> address 330, with exact latency
    send_byte(8'h05);
    send_byte(8'h4A);
    model_byte(8'hB3);
    @(posedge clk);
    #1;
    bus_data   = 8'hB3;
    bus_strobe = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("lat_edge_k", {31'd0, wr_en}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("lat_edge_k1", {31'd0, wr_en}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("lat_edge_k2_en", {31'd0, wr_en}, 32'd1);
    check("lat_edge_k2_addr", {20'd0, wr_addr}, 32'd330);
    check("lat_edge_k2_data", {26'd0, wr_data}, 32'h33);
    @(posedge clk);
    #1 bus_strobe = 1'b0;
    @(negedge clk);
    check("lat_edge_k3", {31'd0, wr_en}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("model_addr_after_single", m_addr, 331);
    send_byte(8'hB4);
    wait_drain(50);
    check("second_pixel_addr", seen_q[seen_q.size()-1], 331);

    // Wrap at the last pixel, and out-of-range address
    send_byte(8'h2F);
    send_byte(8'h7F);
    check("model_addr_3071", m_addr, 3071);
    send_byte(8'h81);
    send_byte(8'h82);
    wait_drain(50);
    check("wrap_first", seen_q[seen_q.size()-2], 3071);
    check("wrap_second", seen_q[seen_q.size()-1], 0);
    send_byte(8'h3F);
    send_byte(8'h7F);
    base = seen_q.size();
    send_byte(8'h85);
    repeat (4) @(posedge clk);
    check("oob_no_write", seen_q.size(), base);
    check("oob_model_addr", m_addr, 0);
    send_byte(8'h86);
    wait_drain(50);
    check("oob_next_addr", seen_q[seen_q.size()-1], 0);

    // Blanking hold and overflow
    act_mode = 1;
    repeat (2) @(posedge clk);
    send_byte(8'h01);
    send_byte(8'h40);
    for (int i = 0; i < 5; i++) begin
      send_byte(8'h90 + 8'(i));
    end
    check("blank_model_addr", m_addr, 68);
    check("blank_overflow", {31'd0, overflow}, 32'd1);
    check("blank_held", {31'd0, wr_en}, 32'd0);
    @(negedge clk);
    act_mode = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("burst_wr_en", {31'd0, wr_en}, 32'd1);
    end
    @(negedge clk);
    check("burst_end", {31'd0, wr_en}, 32'd0);
    check("burst_last_addr", seen_q[seen_q.size()-1], 67);
    wait_drain(10);

    // Fill behind two queued pixels, with active toggling
    do_reset();
    act_mode = 1;
    repeat (2) @(posedge clk);
    send_byte(8'h91);
    send_byte(8'h92);
    base = fill_done;
    send_byte(8'hEA);
    check("fill_busy", {31'd0, busy}, 32'd1);
    tog_cnt = 0;
    act_mode = 2;
    repeat (300) @(posedge clk);
    send_byte(8'h05);
    check("fill_busy_mid", {31'd0, busy}, 32'd1);
    wait_drain(20000);
    @(negedge clk);
    check("fill_busy_done", {31'd0, busy}, 32'd0);
    check("fill_count", fill_done - base, NPix);
    check("fill_overflow", {31'd0, overflow}, 32'd1);
    act_mode = 0;
    repeat (2) @(posedge clk);
    send_byte(8'h9C);
    wait_drain(50);
    check("after_fill_addr", seen_q[seen_q.size()-1], 0);

    // Reset in the middle of a fill
    do_reset();
    base = fill_done;
    send_byte(8'hFD);
    send_byte(8'h07);
    cyc = 0;
    while ((fill_done - base) < 1000 && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    check("midfill_reached", {31'd0, 1'((fill_done - base) >= 1000)}, 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midfill_rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("midfill_rst_busy", {31'd0, busy}, 32'd0);
    check("midfill_rst_overflow", {31'd0, overflow}, 32'd0);
    exp_q.delete();
    m_addr      = 0;
    m_cnt       = 0;
    m_fill_left = 0;
    m_ovf       = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_byte(8'h8F);
    wait_drain(50);
    check("post_reset_addr", seen_q[seen_q.size()-1], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
